// File: rtl/caminho_pkg.sv
// rtl/caminho_pkg.sv - shared state encoding and width helpers for the path request front-end
package caminho_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIAR  = 3'd1,
        AGUARDAR = 3'd2,
        EMITIR   = 3'd3,
        LER      = 3'd4,
        ERRO     = 3'd5
    } estado_t;

    // passos must be able to represent MAX_PASSOS itself
    function automatic int largura_passos(input int max_passos);
        return $clog2(max_passos + 1);
    endfunction

    localparam int MAX_PASSOS_PADRAO      = 64;
    localparam int LARGURA_PASSOS_PADRAO  = largura_passos(MAX_PASSOS_PADRAO);

endpackage

// File: rtl/fila_sincrona.sv
// rtl/fila_sincrona.sv - parametrised synchronous FIFO with full/empty flags
module fila_sincrona #(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  push_ok;
    logic                  pop_ok;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gerenciador_requisicoes_caminho.sv
// rtl/gerenciador_requisicoes_caminho.sv - queues path requests, drives the core and streams the path
module gerenciador_requisicoes_caminho
    import caminho_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int FILA_DEPTH    = 4,
    parameter int MAX_PASSOS    = 64,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_in,
    output logic                     req_ready_out,
    input  logic [ADDR_WIDTH-1:0]    req_fonte_in,
    input  logic [ADDR_WIDTH-1:0]    req_destino_in,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_limite_in,
    output logic                     core_iniciar_out,
    output logic [ADDR_WIDTH-1:0]    core_fonte_out,
    output logic [ADDR_WIDTH-1:0]    core_destino_out,
    input  logic                     core_caminho_pronto_in,
    output logic                     ant_rd_en_out,
    output logic [ADDR_WIDTH-1:0]    ant_rd_addr_out,
    input  logic [ADDR_WIDTH-1:0]    ant_rd_data_in,
    output logic                     cam_valid_out,
    input  logic                     cam_ready_in,
    output logic [ADDR_WIDTH-1:0]    cam_addr_out,
    output logic                     cam_last_out,
    output logic                     cam_erro_out,
    output logic                     ocupado_out
);

    localparam int PW = largura_passos(MAX_PASSOS);
    // the error beat itself is the MAX_PASSOS-th beat of a looping walk
    localparam logic [PW-1:0] PASSOS_LIMITE = PW'(MAX_PASSOS - 1);

    logic                       fila_full;
    logic                       fila_empty;
    logic                       fila_pop;
    logic [2*ADDR_WIDTH-1:0]    fila_dado;

    estado_t                    estado_q, estado_d;
    logic [ADDR_WIDTH-1:0]      fonte_q, fonte_d;
    logic [ADDR_WIDTH-1:0]      destino_q, destino_d;
    logic [ADDR_WIDTH-1:0]      atual_q, atual_d;
    logic [PW-1:0]              passos_q, passos_d;
    logic [PW-1:0]              passos_inc;
    logic [TIMEOUT_WIDTH-1:0]   tmo_q, tmo_d;

    assign req_ready_out = !fila_full;
    assign fila_pop      = (estado_q == OCIOSO) && !fila_empty;
    assign passos_inc    = passos_q + 1'b1;

    fila_sincrona #(
        .DATA_WIDTH (2*ADDR_WIDTH),
        .DEPTH      (FILA_DEPTH)
    ) u_fila (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid_in),
        .push_data ({req_fonte_in, req_destino_in}),
        .pop       (fila_pop),
        .pop_data  (fila_dado),
        .full      (fila_full),
        .empty     (fila_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            fonte_q   <= '0;
            destino_q <= '0;
            atual_q   <= '0;
            passos_q  <= '0;
            tmo_q     <= '0;
        end else begin
            estado_q  <= estado_d;
            fonte_q   <= fonte_d;
            destino_q <= destino_d;
            atual_q   <= atual_d;
            passos_q  <= passos_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        estado_d         = estado_q;
        fonte_d          = fonte_q;
        destino_d        = destino_q;
        atual_d          = atual_q;
        passos_d         = passos_q;
        tmo_d            = tmo_q;
        core_iniciar_out = 1'b0;
        ant_rd_en_out    = 1'b0;
        cam_valid_out    = 1'b0;
        cam_addr_out     = '0;
        cam_last_out     = 1'b0;
        cam_erro_out     = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (!fila_empty) begin
                    fonte_d   = fila_dado[2*ADDR_WIDTH-1:ADDR_WIDTH];
                    destino_d = fila_dado[ADDR_WIDTH-1:0];
                    if (fila_dado[2*ADDR_WIDTH-1:ADDR_WIDTH] == fila_dado[ADDR_WIDTH-1:0]) begin
                        atual_d  = fila_dado[ADDR_WIDTH-1:0];
                        passos_d = '0;
                        estado_d = EMITIR;
                    end else begin
                        estado_d = INICIAR;
                    end
                end
            end
            INICIAR: begin
                core_iniciar_out = 1'b1;
                tmo_d            = '0;
                estado_d         = AGUARDAR;
            end
            AGUARDAR: begin
                if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
                // pronto has priority over a coincident timeout
                if (core_caminho_pronto_in) begin
                    atual_d  = destino_q;
                    passos_d = '0;
                    estado_d = EMITIR;
                end else if ((timeout_limite_in != '0) &&
                             (tmo_q == timeout_limite_in - 1'b1)) begin
                    estado_d = ERRO;
                end
            end
            EMITIR: begin
                cam_valid_out = 1'b1;
                cam_addr_out  = atual_q;
                cam_last_out  = (atual_q == fonte_q);
                if (cam_ready_in) begin
                    if (atual_q == fonte_q) begin
                        estado_d = OCIOSO;
                    end else begin
                        passos_d = passos_inc;
                        if (passos_inc == PASSOS_LIMITE) begin
                            estado_d = ERRO;
                        end else begin
                            ant_rd_en_out = 1'b1;
                            estado_d      = LER;
                        end
                    end
                end
            end
            LER: begin
                atual_d  = ant_rd_data_in;
                estado_d = EMITIR;
            end
            ERRO: begin
                cam_valid_out = 1'b1;
                cam_addr_out  = destino_q;
                cam_last_out  = 1'b1;
                cam_erro_out  = 1'b1;
                if (cam_ready_in) begin
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign ant_rd_addr_out  = ant_rd_en_out ? atual_q : '0;
    assign ocupado_out      = (estado_q != OCIOSO);
    assign core_fonte_out   = ocupado_out ? fonte_q : '0;
    assign core_destino_out = ocupado_out ? destino_q : '0;

endmodule

// File: tb/tb_gerenciador_requisicoes_caminho.sv
// tb/tb_gerenciador_requisicoes_caminho.sv - scoreboard bench for the path request front-end
module tb_gerenciador_requisicoes_caminho;

    localparam int AW = 10;
    localparam int TW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
        logic          erro;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_fonte = '0;
    logic [AW-1:0] req_destino = '0;
    logic [TW-1:0] timeout_limite = '0;
    logic          core_iniciar;
    logic [AW-1:0] core_fonte;
    logic [AW-1:0] core_destino;
    logic          core_pronto;
    logic          ant_rd_en;
    logic [AW-1:0] ant_rd_addr;
    logic [AW-1:0] ant_rd_data = '0;
    logic          cam_valid;
    logic          cam_ready;
    logic [AW-1:0] cam_addr;
    logic          cam_last;
    logic          cam_erro;
    logic          ocupado;

    logic [AW-1:0] ant_mem [1024];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ini_count = 0;
    int pronto_delay = 0;
    int pronto_cnt = 0;
    int stall_left = 0;
    int stall_cycles = 0;
    logic [AW-1:0] stall_addr = '0;

    beat_t         exp_beats [$];
    logic [AW-1:0] exp_ant [$];
    int            ini_cycs [$];
    int            err_start [$];
    int            err_hs [$];

    logic          prev_stall = 1'b0;
    logic          prev_err_valid = 1'b0;
    beat_t         prev_beat;

    always #5 clk = ~clk;

    gerenciador_requisicoes_caminho #(
        .ADDR_WIDTH    (AW),
        .FILA_DEPTH    (4),
        .MAX_PASSOS    (8),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_valid_in           (req_valid),
        .req_ready_out          (req_ready),
        .req_fonte_in           (req_fonte),
        .req_destino_in         (req_destino),
        .timeout_limite_in      (timeout_limite),
        .core_iniciar_out       (core_iniciar),
        .core_fonte_out         (core_fonte),
        .core_destino_out       (core_destino),
        .core_caminho_pronto_in (core_pronto),
        .ant_rd_en_out          (ant_rd_en),
        .ant_rd_addr_out        (ant_rd_addr),
        .ant_rd_data_in         (ant_rd_data),
        .cam_valid_out          (cam_valid),
        .cam_ready_in           (cam_ready),
        .cam_addr_out           (cam_addr),
        .cam_last_out           (cam_last),
        .cam_erro_out           (cam_erro),
        .ocupado_out            (ocupado)
    );

    always @(posedge clk) begin
        if (ant_rd_en) begin
            ant_rd_data <= ant_mem[ant_rd_addr];
        end
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nome, got, exp);
        end
    endtask

    // core and sink models: react just after each rising edge
    initial begin
        cam_ready   = 1'b1;
        core_pronto = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                core_pronto = 1'b0;
                pronto_cnt  = 0;
                cam_ready   = 1'b1;
            end else begin
                core_pronto = 1'b0;
                if (pronto_cnt > 0) begin
                    pronto_cnt--;
                    if (pronto_cnt == 0) core_pronto = 1'b1;
                end
                if (core_iniciar && pronto_delay > 0) pronto_cnt = pronto_delay;
                if (cam_valid && stall_left > 0 && cam_addr == stall_addr) begin
                    cam_ready = 1'b0;
                    stall_left--;
                end else begin
                    cam_ready = 1'b1;
                end
            end
        end
    end

    // monitor: pops the scoreboard on every handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("hold_valid", cam_valid, 1);
                chk("hold_addr", cam_addr, prev_beat.addr);
                chk("hold_last", cam_last, prev_beat.last);
                chk("hold_erro", cam_erro, prev_beat.erro);
            end
            if (cam_valid && !cam_ready) begin
                stall_cycles++;
                chk("no_ant_rd_during_stall", ant_rd_en, 0);
            end
            if (cam_valid && cam_erro && !prev_err_valid) err_start.push_back(cyc);
            if (cam_valid && cam_ready) begin
                if (cam_erro) err_hs.push_back(cyc);
                if (exp_beats.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat addr=%0h last=%0b erro=%0b", cam_addr, cam_last, cam_erro);
                end else begin
                    beat_t e;
                    e = exp_beats.pop_front();
                    chk("beat_addr", cam_addr, e.addr);
                    chk("beat_last", cam_last, e.last);
                    chk("beat_erro", cam_erro, e.erro);
                end
            end
            if (ant_rd_en) begin
                if (exp_ant.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ant_rd addr=%0h", ant_rd_addr);
                end else begin
                    chk("ant_rd_addr", ant_rd_addr, exp_ant.pop_front());
                end
            end
            if (core_iniciar) begin
                ini_count++;
                ini_cycs.push_back(cyc);
            end
            prev_stall     = cam_valid && !cam_ready;
            prev_err_valid = cam_valid && cam_erro;
            prev_beat      = '{addr: cam_addr, last: cam_last, erro: cam_erro};
        end else begin
            prev_stall     = 1'b0;
            prev_err_valid = 1'b0;
        end
    end

    task automatic send_req(input logic [AW-1:0] f, input logic [AW-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_req_timeout ready=%0b required=1", req_ready);
        end
        req_valid   = 1'b1;
        req_fonte   = f;
        req_destino = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((exp_beats.size() != 0 || ocupado) && n < budget);
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout pending=%0d ocupado=%0b", exp_beats.size(), ocupado);
        end
    endtask

    task automatic push_beat(input logic [AW-1:0] a, input logic l, input logic e);
        exp_beats.push_back('{addr: a, last: l, erro: e});
    endtask

    initial begin
        int ini0;
        for (int i = 0; i < 1024; i++) ant_mem[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_cam_valid", cam_valid, 0);
        chk("rst_iniciar", core_iniciar, 0);
        chk("rst_ant_rd_en", ant_rd_en, 0);
        rst = 1'b0;

        // 1: fonte == destino, no core start
        ini0 = ini_count;
        push_beat(10'd5, 1'b1, 1'b0);
        send_req(10'd5, 10'd5);
        wait_done(200);
        chk("t1_no_iniciar", ini_count, ini0);
        chk("t1_ocupado", ocupado, 0);

        // 2: normal three-beat path
        ant_mem[4] = 10'd3;
        ant_mem[3] = 10'd1;
        pronto_delay = 10;
        ini0 = ini_count;
        push_beat(10'd4, 1'b0, 1'b0);
        push_beat(10'd3, 1'b0, 1'b0);
        push_beat(10'd1, 1'b1, 1'b0);
        exp_ant.push_back(10'd4);
        exp_ant.push_back(10'd3);
        send_req(10'd1, 10'd4);
        wait_done(300);
        chk("t2_one_iniciar", ini_count, ini0 + 1);
        chk("t2_ant_reads_done", exp_ant.size(), 0);

        // 3: same path with back-pressure on the node-3 beat
        stall_cycles = 0;
        stall_addr   = 10'd3;
        stall_left   = 3;
        push_beat(10'd4, 1'b0, 1'b0);
        push_beat(10'd3, 1'b0, 1'b0);
        push_beat(10'd1, 1'b1, 1'b0);
        exp_ant.push_back(10'd4);
        exp_ant.push_back(10'd3);
        send_req(10'd1, 10'd4);
        wait_done(300);
        chk("t3_stall_cycles", stall_cycles, 3);
        chk("t3_ant_reads_done", exp_ant.size(), 0);

        // 4: fill the FIFO while the core never answers, then reset
        pronto_delay   = 0;
        timeout_limite = '0;
        ini0 = ini_count;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t4_ready_before_push", req_ready, 1);
            req_valid   = 1'b1;
            req_fonte   = AW'(10 + i);
            req_destino = AW'(20 + i);
            @(negedge clk);
        end
        req_fonte   = 10'd15;
        req_destino = 10'd25;
        for (int i = 0; i < 4; i++) begin
            chk("t4_ready_full", req_ready, 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("t4_ocupado", ocupado, 1);
        chk("t4_one_iniciar", ini_count, ini0 + 1);
        chk("t4_core_fonte", core_fonte, 10);
        chk("t4_core_destino", core_destino, 20);
        rst = 1'b1;
        #1;
        chk("t4_rst_req_ready", req_ready, 1);
        chk("t4_rst_ocupado", ocupado, 0);
        chk("t4_rst_cam_valid", cam_valid, 0);
        chk("t4_rst_iniciar", core_iniciar, 0);
        chk("t4_rst_ant_rd_en", ant_rd_en, 0);
        chk("t4_rst_core_fonte", core_fonte, 0);
        @(negedge clk);
        rst = 1'b0;
        ini0 = ini_count;
        repeat (10) @(negedge clk);
        chk("t4_fifo_empty_idle", ocupado, 0);
        chk("t4_no_new_iniciar", ini_count, ini0);

        // 5: timeout, then the next queued request
        timeout_limite = 16'd20;
        ini_cycs.delete();
        err_start.delete();
        err_hs.delete();
        push_beat(10'd7, 1'b1, 1'b1);
        push_beat(10'd4, 1'b1, 1'b1);
        send_req(10'd2, 10'd7);
        send_req(10'd1, 10'd4);
        wait_done(400);
        if (ini_cycs.size() >= 2 && err_start.size() >= 1 && err_hs.size() >= 1) begin
            chk("t5_erro_after_iniciar", err_start[0] - ini_cycs[0], 21);
            chk("t5_next_iniciar_gap", ini_cycs[1] - err_hs[0], 2);
        end else begin
            checks++;
            errors++;
            $display("FAIL t5_events ini=%0d err=%0d hs=%0d required>=2,1,1", ini_cycs.size(), err_start.size(), err_hs.size());
        end

        // 6: anterior loop hits the beat limit
        timeout_limite = '0;
        pronto_delay   = 3;
        ant_mem[4] = 10'd3;
        ant_mem[3] = 10'd4;
        for (int i = 0; i < 7; i++) begin
            push_beat((i % 2 == 0) ? 10'd4 : 10'd3, 1'b0, 1'b0);
        end
        push_beat(10'd4, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            exp_ant.push_back((i % 2 == 0) ? 10'd4 : 10'd3);
        end
        send_req(10'd1, 10'd4);
        wait_done(400);
        chk("t6_ant_reads_done", exp_ant.size(), 0);
        chk("t6_idle", ocupado, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
